frame_renderer: RTL and testbench

//  Writer side of the 10x20 Tetris frame buffer scanned out by the VGA controller.
//  On request from game logic, composes the locked-board memory and the active falling piece.

---
 rtl/tetris_pkg.sv | 43 ++++
 rtl/tetromino_rom.sv | 50 +++++
 rtl/frame_renderer.sv | 191 +++++++++++++++++++
 tb/tb_frame_renderer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris frame renderer.
//   - board dimension defaults
//   - piece type codes and the per-piece colour table
//   - renderer FSM state type
// Colours are {R,G,B}, active-low: a 0 bit means that gun is on, and 3'b111 is black.
package tetris_pkg;

    localparam int unsigned DEFAULT_COLS = 10;
    localparam int unsigned DEFAULT_ROWS = 20;

    typedef enum logic [2:0] {
        PieceI    = 3'd0,
        PieceO    = 3'd1,
        PieceT    = 3'd2,
        PieceS    = 3'd3,
        PieceZ    = 3'd4,
        PieceJ    = 3'd5,
        PieceL    = 3'd6,
        PieceNone = 3'd7
    } piece_e;

    localparam logic [2:0] EMPTY_COLOUR = 3'b111;

    // I cyan, O yellow, T magenta, S green, Z red, J blue, L white
    localparam logic [2:0] PIECE_COLOUR [0:6] = '{
        3'b100, 3'b001, 3'b010, 3'b101, 3'b011, 3'b110, 3'b000
    };

    typedef enum logic [1:0] {
        StIdle,
        StWaitVbl,
        StRender,
        StFlush
    } render_state_e;

    function automatic logic [2:0] piece_colour(input logic [2:0] piece_type);
        if (piece_type == PieceNone) begin
            return EMPTY_COLOUR;
        end
        return PIECE_COLOUR[piece_type];
    endfunction

endpackage

// File: rtl/tetromino_rom.sv
// Combinational tetromino shape table.
// Ports:
//   piece_type  in  3   0..6 = I,O,T,S,Z,J,L; 7 = no piece
//   piece_rot   in  2   rotation, 90 degree clockwise steps
//   mask        out 16  4x4 occupancy, bit index = row*4 + col
// I and O turn inside the full 4x4 box; the other pieces turn inside the top-left 3x3.
module tetromino_rom
    import tetris_pkg::*;
(
    input  logic [2:0]  piece_type,
    input  logic [1:0]  piece_rot,
    output logic [15:0] mask
);

    always_comb begin
        mask = 16'h0000;
        case ({piece_type, piece_rot})
            5'b000_00: mask = 16'h00F0;
            5'b000_01: mask = 16'h4444;
            5'b000_10: mask = 16'h0F00;
            5'b000_11: mask = 16'h2222;
            5'b001_00: mask = 16'h0660;
            5'b001_01: mask = 16'h0660;
            5'b001_10: mask = 16'h0660;
            5'b001_11: mask = 16'h0660;
            5'b010_00: mask = 16'h0072;
            5'b010_01: mask = 16'h0262;
            5'b010_10: mask = 16'h0270;
            5'b010_11: mask = 16'h0232;
            5'b011_00: mask = 16'h0036;
            5'b011_01: mask = 16'h0462;
            5'b011_10: mask = 16'h0360;
            5'b011_11: mask = 16'h0231;
            5'b100_00: mask = 16'h0063;
            5'b100_01: mask = 16'h0264;
            5'b100_10: mask = 16'h0630;
            5'b100_11: mask = 16'h0132;
            5'b101_00: mask = 16'h0071;
            5'b101_01: mask = 16'h0226;
            5'b101_10: mask = 16'h0470;
            5'b101_11: mask = 16'h0322;
            5'b110_00: mask = 16'h0074;
            5'b110_01: mask = 16'h0622;
            5'b110_10: mask = 16'h0170;
            5'b110_11: mask = 16'h0223;
            default:   mask = 16'h0000;
        endcase
    end

endmodule

// File: rtl/frame_renderer.sv
// Writer side of the Tetris frame buffer. On a start pulse it waits for vertical blank,
// then rewrites every cell in raster order, one per clock, overlaying the latched falling
// piece on the locked-board memory.
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   start                          render request pulse (ignored while busy)
//   vblank                         vertical blank, synchronous to clock
//   piece_valid/type/rot/x/y       active piece, sampled when start is accepted
//   brd_rd_x, brd_rd_y             board read address
//   brd_rd_data                    board colour, valid one cycle after its address
//   fb_we, fb_x, fb_y, fb_data     frame buffer write port
//   busy                           render accepted and not yet complete
//   done                           one-cycle pulse after the final write
module frame_renderer
    import tetris_pkg::*;
#(
    parameter int unsigned COLS = DEFAULT_COLS,
    parameter int unsigned ROWS = DEFAULT_ROWS
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       vblank,
    input  logic       piece_valid,
    input  logic [2:0] piece_type,
    input  logic [1:0] piece_rot,
    input  logic [4:0] piece_x,
    input  logic [5:0] piece_y,
    output logic [3:0] brd_rd_x,
    output logic [4:0] brd_rd_y,
    input  logic [2:0] brd_rd_data,
    output logic       fb_we,
    output logic [3:0] fb_x,
    output logic [4:0] fb_y,
    output logic [2:0] fb_data,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] LAST_CELL = 8'(COLS * ROWS - 1);
    localparam logic [3:0] LAST_COL  = 4'(COLS - 1);

    render_state_e state_q, state_d;

    logic [7:0] cnt_q, cnt_d;
    logic [3:0] x_q, x_d;
    logic [4:0] y_q, y_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       fb_we_q, fb_we_d;
    logic [3:0] fb_x_q, fb_x_d;
    logic [4:0] fb_y_q, fb_y_d;
    logic       cover_q, cover_d;
    logic       latch_en;

    logic       pvalid_q;
    logic [2:0] ptype_q;
    logic [1:0] prot_q;
    logic [4:0] px_q;
    logic [5:0] py_q;

    logic [15:0]       mask;
    logic signed [5:0] dx;
    logic signed [6:0] dy;
    logic              in_box;
    logic              cover_now;

    tetromino_rom u_rom (
        .piece_type (ptype_q),
        .piece_rot  (prot_q),
        .mask       (mask)
    );

    // Piece overlay test for the cell currently being addressed. Offsets are signed so that
    // cells left of / above the box origin fall outside 0..3 and are clipped, never wrapped.
    always_comb begin
        dx        = $signed({2'b00, x_q}) - $signed({px_q[4], px_q});
        dy        = $signed({2'b00, y_q}) - $signed({py_q[5], py_q});
        in_box    = (dx[5:2] == 4'd0) && (dy[6:2] == 5'd0);
        cover_now = pvalid_q && (ptype_q != PieceNone) && in_box && mask[{dy[1:0], dx[1:0]}];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        fb_we_d  = 1'b0;
        fb_x_d   = fb_x_q;
        fb_y_d   = fb_y_q;
        cover_d  = 1'b0;
        latch_en = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    latch_en = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = StWaitVbl;
                end
            end
            StWaitVbl: begin
                if (vblank) begin
                    state_d = StRender;
                end
            end
            StRender: begin
                // Address stage for cell k; its write lands next cycle with the board data.
                fb_we_d = 1'b1;
                fb_x_d  = x_q;
                fb_y_d  = y_q;
                cover_d = cover_now;
                if (cnt_q == LAST_CELL) begin
                    state_d = StFlush;
                    cnt_d   = 8'd0;
                    x_d     = 4'd0;
                    y_d     = 5'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (x_q == LAST_COL) begin
                        x_d = 4'd0;
                        y_d = y_q + 5'd1;
                    end else begin
                        x_d = x_q + 4'd1;
                    end
                end
            end
            StFlush: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            x_q     <= 4'd0;
            y_q     <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fb_we_q <= 1'b0;
            fb_x_q  <= 4'd0;
            fb_y_q  <= 5'd0;
            cover_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fb_we_q <= fb_we_d;
            fb_x_q  <= fb_x_d;
            fb_y_q  <= fb_y_d;
            cover_q <= cover_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pvalid_q <= 1'b0;
            ptype_q  <= 3'd7;
            prot_q   <= 2'd0;
            px_q     <= 5'd0;
            py_q     <= 6'd0;
        end else if (latch_en) begin
            pvalid_q <= piece_valid;
            ptype_q  <= piece_type;
            prot_q   <= piece_rot;
            px_q     <= piece_x;
            py_q     <= piece_y;
        end
    end

    assign brd_rd_x = x_q;
    assign brd_rd_y = y_q;
    assign fb_we    = fb_we_q;
    assign fb_x     = fb_x_q;
    assign fb_y     = fb_y_q;
    // Board data arrives this cycle, aligned with the registered write address.
    assign fb_data  = fb_we_q ? (cover_q ? piece_colour(ptype_q) : brd_rd_data) : 3'b000;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_frame_renderer.sv
module tb_frame_renderer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       vblank;
    logic       piece_valid;
    logic [2:0] piece_type;
    logic [1:0] piece_rot;
    logic [4:0] piece_x;
    logic [5:0] piece_y;
    logic [3:0] brd_rd_x;
    logic [4:0] brd_rd_y;
    logic [2:0] brd_rd_data;
    logic       fb_we;
    logic [3:0] fb_x;
    logic [4:0] fb_y;
    logic [2:0] fb_data;
    logic       busy;
    logic       done;

    always #5 clock = ~clock;

    frame_renderer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .vblank      (vblank),
        .piece_valid (piece_valid),
        .piece_type  (piece_type),
        .piece_rot   (piece_rot),
        .piece_x     (piece_x),
        .piece_y     (piece_y),
        .brd_rd_x    (brd_rd_x),
        .brd_rd_y    (brd_rd_y),
        .brd_rd_data (brd_rd_data),
        .fb_we       (fb_we),
        .fb_x        (fb_x),
        .fb_y        (fb_y),
        .fb_data     (fb_data),
        .busy        (busy),
        .done        (done)
    );

    // Locked-board memory with one-cycle read latency.
    logic [2:0] board [20][10];
    always @(posedge clock) brd_rd_data <= board[brd_rd_y][brd_rd_x];

    typedef struct packed {
        logic [3:0] x;
        logic [4:0] y;
        logic [2:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Shapes from their rotation-0 footprint, turned clockwise in an n x n box.
    function automatic logic [15:0] ref_mask(input int t, input int rot);
        logic [15:0] m, nm;
        int n;
        n = 3;
        case (t)
            0: begin m = 16'h00F0; n = 4; end
            1: begin m = 16'h0660; n = 4; end
            2: m = 16'h0072;
            3: m = 16'h0036;
            4: m = 16'h0063;
            5: m = 16'h0071;
            6: m = 16'h0074;
            default: return 16'h0000;
        endcase
        for (int k = 0; k < rot; k++) begin
            nm = 16'h0000;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (m[r*4+c]) nm[c*4 + (n-1-r)] = 1'b1;
            m = nm;
        end
        return m;
    endfunction

    function automatic logic [2:0] ref_colour(input int t);
        case (t)
            0: return 3'b100;
            1: return 3'b001;
            2: return 3'b010;
            3: return 3'b101;
            4: return 3'b011;
            5: return 3'b110;
            6: return 3'b000;
            default: return 3'b111;
        endcase
    endfunction

    function automatic void fill_board(input bit rnd);
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                board[y][x] = rnd ? 3'($urandom) : 3'b111;
    endfunction

    // Scatter the piece onto a copy of the board, then queue the 200 raster-order writes.
    function automatic void build_expected(input bit valid, input int t, input int rot,
                                           input int px, input int py);
        logic [2:0]  img [20][10];
        logic [15:0] m;
        int ax, ay;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                img[y][x] = board[y][x];
        if (valid && t != 7) begin
            m = ref_mask(t, rot);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    ax = px + c;
                    ay = py + r;
                    if (m[r*4+c] && ax >= 0 && ax < 10 && ay >= 0 && ay < 20)
                        img[ay][ax] = ref_colour(t);
                end
        end
        exp_q.delete();
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
                exp_q.push_back({4'(x), 5'(y), img[y][x]});
    endfunction

    // Start pulse, then scramble the piece inputs so only the latched copy can be right.
    task automatic pulse_start(input logic valid, input int t, input int rot,
                               input int px, input int py);
        piece_valid = valid;
        piece_type  = 3'(t);
        piece_rot   = 2'(rot);
        piece_x     = 5'(px);
        piece_y     = 6'(py);
        start       = 1'b1;
        tick();
        start       = 1'b0;
        piece_valid = 1'($urandom);
        piece_type  = 3'($urandom);
        piece_rot   = 2'($urandom);
        piece_x     = 5'($urandom);
        piece_y     = 6'($urandom);
    endtask

    // Called one tick after the accepting edge. poke_at: after that many writes, pulse start
    // again, move piece_x and drop vblank. reset_at: after that many writes, assert reset.
    task automatic watch_render(input string tag, input int poke_at, input int reset_at,
                                input int exp_first, input int colour_exp,
                                input logic [2:0] colour);
        int  writes  = 0;
        int  first   = -1;
        int  done_at = -1;
        int  dones   = 0;
        int  ccount  = 0;
        wr_t e;
        wr_t got;
        for (int cyc = 1; cyc <= 260; cyc++) begin
            tick();
            start = 1'b0;
            if (fb_we) begin
                if (first < 0) first = cyc;
                got = {fb_x, fb_y, fb_data};
                if (exp_q.size() == 0) begin
                    check({tag, " unexpected write"}, 32'(fb_we), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, " write"}, 32'(got), 32'(e));
                end
                if (fb_data == colour) ccount++;
                writes++;
                if (writes == 100) check({tag, " busy mid"}, 32'(busy), 32'd1);
                if (writes == poke_at) begin
                    start   = 1'b1;
                    piece_x = 5'd6;
                    vblank  = 1'b0;
                end
                if (writes == reset_at) begin
                    reset_n = 1'b0;
                    #1;
                    check({tag, " we on reset"}, 32'(fb_we), 32'd0);
                    check({tag, " busy on reset"}, 32'(busy), 32'd0);
                    check({tag, " done on reset"}, 32'(done), 32'd0);
                    exp_q.delete();
                    return;
                end
            end
            if (done) begin
                dones++;
                if (done_at < 0) done_at = cyc;
            end
            if (done_at >= 0 && cyc >= done_at + 10) break;
        end
        check({tag, " write count"}, 32'(writes), 32'd200);
        check({tag, " leftover"}, 32'(exp_q.size()), 32'd0);
        check({tag, " done count"}, 32'(dones), 32'd1);
        check({tag, " first write"}, 32'(first), 32'(exp_first));
        check({tag, " done latency"}, 32'(done_at - first), 32'd200);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        if (colour_exp >= 0) check({tag, " piece cells"}, 32'(ccount), 32'(colour_exp));
    endtask

    initial begin
        reset_n     = 1'b1;
        start       = 1'b0;
        vblank      = 1'b0;
        piece_valid = 1'b0;
        piece_type  = 3'd7;
        piece_rot   = 2'd0;
        piece_x     = 5'd0;
        piece_y     = 6'd0;
        fill_board(1'b0);
        #2 reset_n = 1'b0;
        #10;
        check("rst fb_we", 32'(fb_we), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst fb_x", 32'(fb_x), 32'd0);
        check("rst fb_y", 32'(fb_y), 32'd0);
        check("rst fb_data", 32'(fb_data), 32'd0);
        check("rst brd_rd_x", 32'(brd_rd_x), 32'd0);
        check("rst brd_rd_y", 32'(brd_rd_y), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // 1: no piece, board passes straight through; vblank already high.
        fill_board(1'b1);
        vblank = 1'b1;
        build_expected(1'b0, 2, 0, 0, 0);
        pulse_start(1'b0, 2, 0, 4, 0);
        watch_render("t1", -1, -1, 2, -1, 3'b000);

        // 2: request outside blanking must wait for vblank.
        fill_board(1'b1);
        vblank = 1'b0;
        build_expected(1'b1, 3, 2, 7, 15);
        pulse_start(1'b1, 3, 2, 7, 15);
        for (int i = 0; i < 50; i++) begin
            check("t2 wait we", 32'(fb_we), 32'd0);
            check("t2 wait busy", 32'(busy), 32'd1);
            tick();
        end
        vblank = 1'b1;
        watch_render("t2", -1, -1, 2, -1, 3'b000);

        // 3: T piece on an empty board.
        fill_board(1'b0);
        build_expected(1'b1, 2, 0, 4, 0);
        pulse_start(1'b1, 2, 0, 4, 0);
        watch_render("t3", -1, -1, 2, 4, 3'b010);

        // 4: I piece clipped on the left edge, then on the bottom edge.
        build_expected(1'b1, 0, 1, -2, 5);
        pulse_start(1'b1, 0, 1, -2, 5);
        watch_render("t4a", -1, -1, 2, 4, 3'b100);
        build_expected(1'b1, 0, 1, 3, 17);
        pulse_start(1'b1, 0, 1, 3, 17);
        watch_render("t4b", -1, -1, 2, 3, 3'b100);

        // 5: second start mid-render is ignored and the latched piece is used.
        fill_board(1'b1);
        build_expected(1'b1, 2, 3, 2, 3);
        pulse_start(1'b1, 2, 3, 2, 3);
        watch_render("t5", 50, -1, 2, -1, 3'b000);
        vblank = 1'b1;
        tick();
        tick();
        check("t5 idle after", 32'(busy), 32'd0);

        // 6: reset mid-render, then a complete render afterwards.
        fill_board(1'b1);
        build_expected(1'b1, 6, 1, 0, 0);
        pulse_start(1'b1, 6, 1, 0, 0);
        watch_render("t6a", -1, 100, 2, -1, 3'b000);
        tick();
        reset_n = 1'b1;
        tick();
        check("t6 busy idle", 32'(busy), 32'd0);
        fill_board(1'b1);
        build_expected(1'b1, 4, 2, 8, 18);
        pulse_start(1'b1, 4, 2, 8, 18);
        watch_render("t6b", -1, -1, 2, -1, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
